mem_bus_arbiter: RTL

- Multicore RAM arbiter between CPUS cores' instruction and data caches and the single-ported RAM.
- Each core presents independent I-fetch and D-read/write requests; at most one request owns the RAM at a time.
- Ownership is registered and held until the RAM reports ACCESS, then rotated round-robin across cores.
- Within a core, D beats I.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter giving one core's I-fetch or D-access ownership of a single-ported RAM.
// Latency: request seen in IDLE at edge k drives the RAM from cycle k+1; wait drops combinationally on ACCESS; one IDLE bubble between grants.
// Backpressure: the owner's wait stays high through FREE/BUSY/ERROR and drops for exactly one cycle on ACCESS; non-owners always see wait=1.
//
// Ports:
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   iREN, iaddr               per-core instruction fetch request and address
//   dREN, dWEN, daddr, dstore per-core data read/write request, address and write data
//   iwait, dwait              per-core wait, low for one cycle when that core's request completes
//   iload, dload              ramload broadcast to every core slot
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate   single RAM port
module mem_bus_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int         OW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [OW-1:0]   rr, rr_nxt;
    logic            otype, otype_nxt;   // 1: data access owns the RAM, 0: instruction fetch

    // Arbitration result while IDLE
    logic            found;
    logic [OW-1:0]   win;
    logic            win_d;

    // Owner's request lines, muxed by the registered owner index
    logic              sel_iren, sel_dren, sel_dwen;
    logic [WORD_W-1:0] sel_iaddr, sel_daddr, sel_dstore;
    logic              own_req;
    logic              done;

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Owner mux. Constant loop indices keep every select statically sized.
    always_comb begin
        sel_iren   = 1'b0;
        sel_dren   = 1'b0;
        sel_dwen   = 1'b0;
        sel_iaddr  = '0;
        sel_daddr  = '0;
        sel_dstore = '0;
        for (int n = 0; n < CPUS; n++) begin
            if (owner == OW'(n)) begin
                sel_iren   = iREN[n];
                sel_dren   = dREN[n];
                sel_dwen   = dWEN[n];
                sel_iaddr  = iaddr[n*WORD_W +: WORD_W];
                sel_daddr  = daddr[n*WORD_W +: WORD_W];
                sel_dstore = dstore[n*WORD_W +: WORD_W];
            end
        end
        own_req = otype ? (sel_dren | sel_dwen) : sel_iren;
        done    = (state == OWN) && own_req && (ramstate == RAM_ACCESS);
    end

    // Round-robin scan: position k in the rotation is core (rr+k) mod CPUS;
    // the first core with any request wins and its D request beats its I request.
    always_comb begin
        found = 1'b0;
        win   = '0;
        win_d = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            for (int n = 0; n < CPUS; n++) begin
                if (!found && (n == ((int'(rr) + k) % CPUS)) &&
                    (iREN[n] | dREN[n] | dWEN[n])) begin
                    found = 1'b1;
                    win   = OW'(n);
                    win_d = dREN[n] | dWEN[n];
                end
            end
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            owner <= '0;
            otype <= 1'b0;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            otype <= otype_nxt;
            rr    <= rr_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        otype_nxt = otype;
        rr_nxt    = rr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWN;
                    owner_nxt = win;
                    otype_nxt = win_d;
                end
            end
            OWN: begin
                if (!own_req) begin
                    // Abort: owner withdrew; pointer stays so it is not penalised
                    state_nxt = IDLE;
                end else if (done) begin
                    state_nxt = IDLE;
                    rr_nxt    = (int'(owner) == CPUS - 1) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        if (state == OWN) begin
            if (otype) begin
                ramREN   = sel_dren;
                ramWEN   = sel_dwen;
                ramaddr  = sel_daddr;
                ramstore = sel_dstore;
            end else begin
                ramREN   = sel_iren;
                ramaddr  = sel_iaddr;
            end
            for (int n = 0; n < CPUS; n++) begin
                if (done && (owner == OW'(n))) begin
                    if (otype) begin
                        dwait[n] = 1'b0;
                    end else begin
                        iwait[n] = 1'b0;
                    end
                end
            end
        end
    end

endmodule
